// File: rtl/snax_reshuffler_job_scheduler.sv
// rtl/snax_reshuffler_job_scheduler.sv - job queue and issue/completion scheduler for the reshuffler
module snax_reshuffler_job_scheduler #(
    parameter int QueueDepth   = 4,
    parameter int RegDataWidth = 32,
    parameter int CntWidth     = 16,
    parameter int StartTimeout = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [RegDataWidth-1:0]         job_cfg_i,
    input  logic                            job_valid_i,
    output logic                            job_ready_o,
    output logic [RegDataWidth-1:0]         acc_ctrl_o,
    output logic                            acc_ctrl_valid_o,
    input  logic                            acc_ctrl_ready_i,
    input  logic                            acc_busy_i,
    input  logic                            clear_done_i,
    output logic [$clog2(QueueDepth):0]     queue_count_o,
    output logic [CntWidth-1:0]             done_count_o,
    output logic                            sched_busy_o,
    output logic                            done_pulse_o
);

    localparam int PtrWidth   = $clog2(QueueDepth);
    localparam int CountWidth = PtrWidth + 1;
    localparam int TimerWidth = $clog2(StartTimeout + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [RegDataWidth-1:0] mem_q [QueueDepth];
    logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0]   count_q;
    logic [TimerWidth-1:0]   timer_q, timer_d;
    logic [CntWidth-1:0]     done_q;
    logic                    push, pop, complete;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign job_ready_o   = (count_q < CountWidth'(QueueDepth));
    assign push          = job_valid_i && job_ready_o;
    assign pop           = acc_ctrl_valid_o && acc_ctrl_ready_i;
    assign queue_count_o = count_q;
    assign done_count_o  = done_q;
    assign done_pulse_o  = complete;
    assign sched_busy_o  = (state_q != IDLE) || (count_q != '0);

    // Descriptor storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= job_cfg_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CountWidth'(1);
                2'b01:   count_q <= count_q - CountWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State and start-timeout registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, accelerator handshake and completion detection.
    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        acc_ctrl_valid_o = 1'b0;
        acc_ctrl_o       = '0;
        complete         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                acc_ctrl_valid_o = 1'b1;
                acc_ctrl_o       = mem_q[rd_ptr_q];
                if (acc_ctrl_ready_i) begin
                    state_d = WAIT_START;
                    timer_d = '0;
                end
            end
            WAIT_START: begin
                if (acc_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TimerWidth'(StartTimeout - 1)) begin
                    // Accelerator never went busy: treat as a zero-length job.
                    complete = 1'b1;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end
            WAIT_DONE: begin
                if (!acc_busy_i) complete = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            state_d = (count_q != '0) ? ISSUE : IDLE;
        end
    end

    // Completed-job counter; a clear coinciding with a completion keeps that job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else if (clear_done_i) begin
            done_q <= complete ? CntWidth'(1) : '0;
        end else if (complete) begin
            done_q <= done_q + CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_snax_reshuffler_job_scheduler.sv
// tb/tb_snax_reshuffler_job_scheduler.sv - scoreboard bench for the reshuffler job scheduler
module tb_snax_reshuffler_job_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] job_cfg_i;
    logic        job_valid_i;
    logic        job_ready_o;
    logic [31:0] acc_ctrl_o;
    logic        acc_ctrl_valid_o;
    logic        acc_ctrl_ready_i;
    logic        acc_busy_i;
    logic        clear_done_i;
    logic [2:0]  queue_count_o;
    logic [15:0] done_count_o;
    logic        sched_busy_o;
    logic        done_pulse_o;

    logic [31:0] w_cfg;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ctrl;
    logic        w_ctrl_valid;
    logic        w_clear;
    logic [2:0]  w_count;
    logic [3:0]  w_done;
    logic        w_sbusy;
    logic        w_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int issued   = 0;
    int viol     = 0;
    logic prev_hs = 1'b0;
    logic [31:0] sb[$];

    always #5 clk_i = ~clk_i;

    snax_reshuffler_job_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .job_cfg_i(job_cfg_i), .job_valid_i(job_valid_i),
        .job_ready_o(job_ready_o), .acc_ctrl_o(acc_ctrl_o), .acc_ctrl_valid_o(acc_ctrl_valid_o),
        .acc_ctrl_ready_i(acc_ctrl_ready_i), .acc_busy_i(acc_busy_i), .clear_done_i(clear_done_i),
        .queue_count_o(queue_count_o), .done_count_o(done_count_o), .sched_busy_o(sched_busy_o),
        .done_pulse_o(done_pulse_o)
    );

    snax_reshuffler_job_scheduler #(.QueueDepth(4), .RegDataWidth(32), .CntWidth(4), .StartTimeout(2)) dut_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .job_cfg_i(w_cfg), .job_valid_i(w_valid),
        .job_ready_o(w_ready), .acc_ctrl_o(w_ctrl), .acc_ctrl_valid_o(w_ctrl_valid),
        .acc_ctrl_ready_i(1'b1), .acc_busy_i(1'b0), .clear_done_i(w_clear),
        .queue_count_o(w_count), .done_count_o(w_done), .sched_busy_o(w_sbusy),
        .done_pulse_o(w_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue monitor: compares every accepted control word against the scoreboard.
    always @(negedge clk_i) begin
        if (acc_ctrl_valid_o && acc_ctrl_ready_i) begin
            issued++;
            if (sb.size() == 0) check("unexpected_issue", acc_ctrl_o, 64'hdead);
            else check("issue_order", acc_ctrl_o, sb.pop_front());
        end
        if (!acc_ctrl_valid_o && acc_ctrl_o != 32'h0) viol++;
        if (prev_hs && acc_ctrl_valid_o) viol++;
        prev_hs = acc_ctrl_valid_o && acc_ctrl_ready_i;
        if (done_pulse_o) pulses++;
    end

    task automatic push_job(input logic [31:0] d);
        int k;
        job_cfg_i   = d;
        job_valid_i = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk_i);
            if (job_ready_o) break;
        end
        @(posedge clk_i);
        #1;
        job_valid_i = 1'b0;
        job_cfg_i   = 32'h0;
        if (k < 500) sb.push_back(d);
        else check("push_accept_timeout", 0, 1);
    endtask

    task automatic wait_hs(input string tag);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk_i);
            if (acc_ctrl_valid_o && acc_ctrl_ready_i) break;
        end
        if (k >= 500) check(tag, 0, 1);
    endtask

    task automatic wait_pulses(input string tag, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < 3000 && seen < n; k++) begin
            @(negedge clk_i);
            if (done_pulse_o) seen++;
        end
        check(tag, seen, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        rst_ni = 1'b0; job_cfg_i = '0; job_valid_i = 1'b0; acc_ctrl_ready_i = 1'b0;
        acc_busy_i = 1'b0; clear_done_i = 1'b0;
        w_cfg = '0; w_valid = 1'b0; w_clear = 1'b0;
        #3;
        check("rst_job_ready", job_ready_o, 1);
        check("rst_count", queue_count_o, 0);
        check("rst_done_count", done_count_o, 0);
        check("rst_ctrl_valid", acc_ctrl_valid_o, 0);
        check("rst_ctrl", acc_ctrl_o, 0);
        check("rst_sched_busy", sched_busy_o, 0);
        check("rst_done_pulse", done_pulse_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single job with busy for three cycles.
        acc_ctrl_ready_i = 1'b1;
        push_job(32'hA5);
        wait_hs("a5_hs_timeout");
        @(posedge clk_i); #1 acc_busy_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 acc_busy_i = 1'b0;
        wait_pulses("a5_done_pulse", 1);
        check("a5_done_before_edge", done_count_o, 0);
        @(posedge clk_i); #1;
        check("a5_done_count", done_count_o, 1);
        repeat (3) @(posedge clk_i); #1;
        check("a5_single_pulse", pulses, 1);
        check("a5_single_issue", issued, 1);

        // Accelerator never goes busy: timeout completion.
        push_job(32'h36);
        wait_hs("to_hs_timeout");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            n++;
            if (done_pulse_o) break;
        end
        check("timeout_latency", n, 8);
        @(posedge clk_i); #1;
        check("timeout_done_count", done_count_o, 2);

        // Fill the queue with the accelerator stalled.
        acc_ctrl_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_job(32'hD0 + i);
        job_cfg_i = 32'hDEAD; job_valid_i = 1'b1;
        @(negedge clk_i);
        check("full_job_ready", job_ready_o, 0);
        check("full_count", queue_count_o, 4);
        check("full_ctrl_valid", acc_ctrl_valid_o, 1);
        check("full_ctrl_head", acc_ctrl_o, 32'hD0);
        check("full_sched_busy", sched_busy_o, 1);
        repeat (2) @(posedge clk_i);
        #1 job_valid_i = 1'b0;
        @(negedge clk_i);
        check("full_fifth_rejected", queue_count_o, 4);
        check("full_head_stable", acc_ctrl_o, 32'hD0);
        acc_ctrl_ready_i = 1'b1;
        wait_pulses("full_drain", 4);
        @(posedge clk_i); #1;
        check("full_done_count", done_count_o, 6);

        // Simultaneous push and pop at occupancy two, across pointer wrap.
        acc_ctrl_ready_i = 1'b0;
        push_job(32'hB1);
        push_job(32'hB2);
        acc_ctrl_ready_i = 1'b1;
        job_cfg_i = 32'hB3; job_valid_i = 1'b1;
        sb.push_back(32'hB3);
        @(negedge clk_i);
        check("pp_count_before", queue_count_o, 2);
        check("pp_ctrl_valid", acc_ctrl_valid_o, 1);
        check("pp_job_ready", job_ready_o, 1);
        @(posedge clk_i); #1;
        job_valid_i = 1'b0;
        check("pp_count_after", queue_count_o, 2);
        wait_pulses("pp_drain", 3);
        @(posedge clk_i); #1;
        check("pp_done_count", done_count_o, 9);

        // Counter wrap and clear on a narrow-counter instance.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    int k;
                    w_cfg = i; w_valid = 1'b1;
                    for (k = 0; k < 200; k++) begin
                        @(negedge clk_i);
                        if (w_ready) break;
                    end
                    @(posedge clk_i); #1;
                    w_valid = 1'b0;
                end
            end
            begin
                int seen;
                seen = 0;
                for (int k = 0; k < 2000 && seen < 16; k++) begin
                    @(negedge clk_i);
                    if (w_pulse) begin
                        seen++;
                        if (seen == 16) check("wrap_pre_value", w_done, 4'hF);
                    end
                end
                check("wrap_completions", seen, 16);
            end
        join
        @(posedge clk_i); #1;
        check("wrap_to_zero", w_done, 0);
        w_cfg = 32'h77; w_valid = 1'b1;
        @(posedge clk_i); #1 w_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (w_pulse) begin n = 1; break; end
        end
        check("clr_pulse_seen", n, 1);
        w_clear = 1'b1;
        @(posedge clk_i); #1 w_clear = 1'b0;
        check("clear_with_completion", w_done, 1);
        w_clear = 1'b1;
        @(posedge clk_i); #1 w_clear = 1'b0;
        check("clear_alone", w_done, 0);

        // Reset while in WAIT_DONE with two jobs queued.
        acc_ctrl_ready_i = 1'b1;
        push_job(32'hE1);
        wait_hs("rst_hs_timeout");
        @(posedge clk_i); #1 acc_busy_i = 1'b1;
        push_job(32'hE2);
        push_job(32'hE3);
        @(negedge clk_i);
        check("pre_rst_count", queue_count_o, 2);
        p0 = pulses;
        #1 rst_ni = 1'b0;
        #1;
        check("mid_rst_count", queue_count_o, 0);
        check("mid_rst_ctrl_valid", acc_ctrl_valid_o, 0);
        check("mid_rst_done_pulse", done_pulse_o, 0);
        check("mid_rst_done_count", done_count_o, 0);
        check("mid_rst_sched_busy", sched_busy_o, 0);
        sb.delete();
        acc_busy_i = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        check("rst_no_pulse", pulses, p0);

        // First push after release is taken on the first edge.
        @(negedge clk_i);
        rst_ni = 1'b1;
        job_cfg_i = 32'hC1; job_valid_i = 1'b1;
        @(posedge clk_i); #1;
        job_valid_i = 1'b0;
        check("first_push_count", queue_count_o, 1);
        sb.push_back(32'hC1);
        wait_pulses("c1_done", 1);
        @(posedge clk_i); #1;
        check("c1_done_count", done_count_o, 1);
        check("scoreboard_empty", sb.size(), 0);
        check("ctrl_protocol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snax_reshuffler_job_scheduler.md
SNAX_RESHUFFLER_JOB_SCHEDULER -- requirements
Module: snax_reshuffler_job_scheduler

Interface
REQ-001: Parameter QueueDepth, default 4, SHALL set the number of job-queue entries (power of two, 2..16).
REQ-002: Parameter RegDataWidth, default 32, SHALL set the job descriptor width.
REQ-003: Parameter CntWidth, default 16, SHALL set the completed-job counter width.
REQ-004: Parameter StartTimeout, default 8, SHALL set the cycles to wait for accelerator busy after issue.
REQ-005: clk_i  input  1  SHALL be the single clock; all state is rising-edge.
REQ-006: rst_ni  input  1  SHALL be the asynchronous active-low reset.
REQ-007: job_cfg_i  input  RegDataWidth  SHALL carry the job descriptor from the CSR manager.
REQ-008: job_valid_i / job_ready_o  input / output  1 each  SHALL form the job push handshake.
REQ-009: acc_ctrl_o  output  RegDataWidth  SHALL drive the reshuffler control word.
REQ-010: acc_ctrl_valid_o / acc_ctrl_ready_i  output / input  1 each  SHALL form the accelerator control handshake.
REQ-011: acc_busy_i  input  1  SHALL be the reshuffler busy flag.
REQ-012: clear_done_i  input  1  SHALL synchronously clear the done counter.
REQ-013: queue_count_o  output  $clog2(QueueDepth)+1  SHALL report occupied queue entries.
REQ-014: done_count_o  output  CntWidth  SHALL report jobs completed since reset or clear.
REQ-015: sched_busy_o  output  1  SHALL be high when the FSM is not IDLE or queue_count_o != 0.
REQ-016: done_pulse_o  output  1  SHALL pulse for one cycle per completed job.

Function
REQ-017: A job SHALL be pushed when job_valid_i && job_ready_o; job_ready_o = (queue_count_o < QueueDepth), independent of same-cycle pops.
REQ-018: The queue SHALL be FIFO; wrap-around of read/write pointers SHALL preserve order.
REQ-019: Simultaneous push and pop SHALL leave queue_count_o unchanged.
REQ-020: FSM states SHALL be IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-021: IDLE -> ISSUE on the cycle after queue_count_o != 0 is observed; a push into an empty queue reaches ISSUE no earlier than the next cycle.
REQ-022: In ISSUE, acc_ctrl_valid_o SHALL be 1 and acc_ctrl_o SHALL equal the queue head, held stable until acc_ctrl_ready_i.
REQ-023: On acc_ctrl_valid_o && acc_ctrl_ready_i the head SHALL be popped and FSM SHALL enter WAIT_START with the timeout counter cleared.
REQ-024: acc_ctrl_valid_o SHALL be 0 in all states except ISSUE.
REQ-025: WAIT_START: acc_busy_i = 1 -> WAIT_DONE; otherwise after StartTimeout cycles without busy the job SHALL complete (zero-length job).
REQ-026: WAIT_DONE: acc_busy_i = 0 -> job completes.
REQ-027: On completion done_pulse_o SHALL be 1 for exactly that cycle, done_count_o SHALL increment (wrapping modulo 2^CntWidth), and FSM SHALL go to ISSUE if queue non-empty, else IDLE.
REQ-028: clear_done_i with a same-cycle completion SHALL yield done_count_o = 1; clear alone yields 0.
REQ-029: acc_ctrl_o SHALL be 0 when not in ISSUE.
REQ-030: Each job issue-to-issue gap SHALL be at least one cycle (no back-to-back valid across jobs).

Reset
REQ-031: On rst_ni low, state SHALL be IDLE, queue empty, pointers 0, done_count_o 0, done_pulse_o 0, acc_ctrl_valid_o 0, acc_ctrl_o 0, job_ready_o 1, sched_busy_o 0, asynchronously.
REQ-032: Reset mid-job SHALL discard all queued and in-flight jobs without a done pulse.
REQ-033: After reset release, the first push SHALL be accepted on the first rising edge with job_valid_i high.

Verification
REQ-034: Push 0xA5 with acc_ctrl_ready_i=1; busy high 3 cycles then low -> acc_ctrl_o=0xA5 for one cycle, one done_pulse_o, done_count_o=1.
REQ-035: Push 5 jobs with acc_ctrl_ready_i=0, QueueDepth=4 -> 4 accepted, job_ready_o=0, queue_count_o=4; release ready -> issued in push order.
REQ-036: Issue job, acc_busy_i held 0 -> completion exactly StartTimeout cycles after handshake, done_count_o increments.
REQ-037: done_count_o=0xFFFF, one completion -> 0x0000; clear_done_i coincident with completion -> 1.
REQ-038: Assert rst_ni low during WAIT_DONE with 2 queued -> queue_count_o=0, no done pulse, acc_ctrl_valid_o=0.
REQ-039: Push and issue in the same cycle at queue_count_o=2 -> queue_count_o stays 2, order preserved across pointer wrap.
